// File: rtl/fp16bit_wallace_tree.sv
// fp16bit_wallace_tree: IEEE-754 binary16 multiplier with a Wallace-tree
// significand multiplier and one registered output stage (latency 1).
// Optional macro FP16_INPUT_REG_EN adds an operand register stage in front of
// the tree (latency 2); the function and the flags are unchanged.
// Operands with exponent 0 are treated as zero (no subnormal support).
// Rounding is round-to-nearest-even. Results that overflow saturate to
// signed infinity, and results that underflow flush to signed zero.
module fp16bit_wallace_tree (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_operand,
    input  logic [15:0] b_operand,
    output logic [15:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    // Carry-save pair: two rows whose sum equals the sum of the compressed inputs.
    typedef struct packed {
        logic [21:0] sum;
        logic [21:0] carry;
    } csa_t;

    // 3:2 compressor applied bitwise across a row (one full adder per column).
    function automatic csa_t csa3(input logic [21:0] x, input logic [21:0] y,
                                  input logic [21:0] z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (y & z) | (x & z)) << 1;
        return r;
    endfunction

    // 2:2 compressor applied bitwise across a row (one half adder per column).
    function automatic csa_t ha2(input logic [21:0] x, input logic [21:0] y);
        csa_t r;
        r.sum   = x ^ y;
        r.carry = (x & y) << 1;
        return r;
    endfunction

    logic [15:0] a_in;
    logic [15:0] b_in;

`ifdef FP16_INPUT_REG_EN
    // Operand register stage in front of the tree; reset clears it to zero.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (rst) begin
            a_in <= '0;
            b_in <= '0;
        end else begin
            a_in <= a_operand;
            b_in <= b_operand;
        end
    end
`else
    assign a_in = a_operand;
    assign b_in = b_operand;
`endif

    // Field decode
    logic        sign;
    logic [4:0]  exp_a;
    logic [4:0]  exp_b;
    logic [10:0] sig_a;
    logic [10:0] sig_b;
    logic        exc;
    logic        zero_op;

    assign sign    = a_in[15] ^ b_in[15];
    assign exp_a   = a_in[14:10];
    assign exp_b   = b_in[14:10];
    assign sig_a   = {1'b1, a_in[9:0]};
    assign sig_b   = {1'b1, b_in[9:0]};
    assign exc     = (exp_a == 5'h1f) || (exp_b == 5'h1f);
    assign zero_op = (exp_a == 5'h00) || (exp_b == 5'h00);

    // Partial-product rows: row i is sig_a gated by sig_b[i], weighted by 2^i.
    logic [21:0] pp [11];

    // Build the 121 AND partial-product bits as 11 shifted rows.
    always_comb begin
        for (int i = 0; i < 11; i++) begin
            pp[i] = {11'b0, sig_a & {11{sig_b[i]}}} << i;
        end
    end

    // Wallace reduction: 11 rows -> 8 -> 6 -> 4 -> 3 -> 2.
    // Bits carried past column 21 are dropped. The true product is below
    // 2^22, so the modulo-2^22 sum of the final two rows is still exact.
    csa_t l1_0, l1_1, l1_2, l1_3;
    csa_t l2_0, l2_1;
    csa_t l3_0, l3_1;
    csa_t l4_0;
    csa_t l5_0;

    assign l1_0 = csa3(pp[0], pp[1], pp[2]);
    assign l1_1 = csa3(pp[3], pp[4], pp[5]);
    assign l1_2 = csa3(pp[6], pp[7], pp[8]);
    assign l1_3 = ha2(pp[9], pp[10]);

    assign l2_0 = csa3(l1_0.sum, l1_0.carry, l1_1.sum);
    assign l2_1 = csa3(l1_1.carry, l1_2.sum, l1_2.carry);

    assign l3_0 = csa3(l2_0.sum, l2_0.carry, l2_1.sum);
    assign l3_1 = csa3(l2_1.carry, l1_3.sum, l1_3.carry);

    assign l4_0 = csa3(l3_0.sum, l3_0.carry, l3_1.sum);

    assign l5_0 = csa3(l4_0.sum, l4_0.carry, l3_1.carry);

    // Final carry-propagate adder
    logic [21:0] product;
    assign product = l5_0.sum + l5_0.carry;

    // Normalisation, rounding and exponent arithmetic
    logic              norm_n;
    logic [21:0]       norm;
    logic              guard;
    logic              sticky;
    logic              round_inc;
    logic [10:0]       frac_rnd;
    logic              round_carry;
    logic signed [6:0] exp_sum;

    // Normalise so the leading one sits at bit 21, then round to nearest even.
    always_comb begin
        // NOTE: every combinational output is assigned up front so that no
        // path through the block can leave a value held, which would imply a latch.
        norm_n      = product[21];
        norm        = product[21] ? product : (product << 1);
        guard       = norm[10];
        sticky      = |norm[9:0];
        round_inc   = guard & (sticky | norm[11]);
        frac_rnd    = {1'b0, norm[20:11]} + {10'b0, round_inc};
        round_carry = frac_rnd[10];
        exp_sum     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 7'sd15
                    + $signed({6'b0, norm_n}) + $signed({6'b0, round_carry});
    end

    // Next-state values for the output register
    logic [15:0] result_d;
    logic        exc_d;
    logic        ovf_d;
    logic        unf_d;

    // Output selection, in priority order: exception, zero operand,
    // overflow, underflow, then a normal result.
    always_comb begin
        result_d = {sign, exp_sum[4:0], frac_rnd[9:0]};
        exc_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (exc) begin
            result_d = 16'h0000;
            exc_d    = 1'b1;
        end else if (zero_op) begin
            result_d = {sign, 15'b0};
        end else if (exp_sum >= 7'sd31) begin
            result_d = {sign, 5'b11111, 10'b0};
            ovf_d    = 1'b1;
        end else if (exp_sum <= 7'sd0) begin
            result_d = {sign, 15'b0};
            unf_d    = 1'b1;
        end
    end

    // Output register; reset overrides any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= 16'h0000;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            result    <= result_d;
            Exception <= exc_d;
            Overflow  <= ovf_d;
            Underflow <= unf_d;
        end
    end

endmodule

// File: tb/tb_fp16bit_wallace_tree.sv
// Directed testbench for fp16bit_wallace_tree. The expected value of each
// vector is hand-computed. A queue that is LAT entries deep aligns each
// expectation with the output it belongs to. Both builds are supported
// (FP16_INPUT_REG_EN defined or undefined).
module tb_fp16bit_wallace_tree;

`ifdef FP16_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_operand = '0;
    logic [15:0] b_operand = '0;
    logic [15:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [18:0] want;
    } exp_t;

    exp_t pipe[$];

    fp16bit_wallace_tree dut (
        .clk       (clk),
        .rst       (rst),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    // Compare {result, Exception, Overflow, Underflow} against the expectation.
    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed result=%h EOU=%b, required result=%h EOU=%b",
                   tag, got[18:3], got[2:0], want[18:3], want[2:0]);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then sample 1 time unit
    // after the rising edge. A reset cycle checks the cleared outputs directly.
    task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input string tag, input logic [15:0] res, input logic [2:0] flags);
        exp_t e;
        @(negedge clk);
        rst       = r;
        a_operand = a;
        b_operand = b;
        @(posedge clk);
        #1;
        if (r) begin
            check(tag, {result, Exception, Overflow, Underflow}, 19'h0);
            pipe.delete();
            if (LAT == 2) begin
                // The cleared operand registers produce 0x0000 x 0x0000 next.
                e.tag  = {tag, "_zero_in"};
                e.want = 19'h0;
                pipe.push_back(e);
            end
        end else begin
            e.tag  = tag;
            e.want = {res, flags};
            pipe.push_back(e);
            if (pipe.size() == LAT) begin
                e = pipe.pop_front();
                check(e.tag, {result, Exception, Overflow, Underflow}, e.want);
            end
        end
    endtask

    initial begin
        // flags = {Exception, Overflow, Underflow}
        step(1'b1, 16'h4AAC, 16'hC713, "reset0", 16'h0000, 3'b000);
        step(1'b1, 16'h0000, 16'h0000, "reset1", 16'h0000, 3'b000);

        step(1'b0, 16'h4AAC, 16'hC713, "mul_13p34_x_m7p07", 16'hD5E6, 3'b000);
        step(1'b0, 16'hCC80, 16'h48C0, "exact_m18_x_9p5",   16'hD958, 3'b000);
        step(1'b0, 16'h7BFF, 16'h7BFF, "ovf_max_sq",        16'h7C00, 3'b010);
        step(1'b0, 16'h7C00, 16'h3C00, "exc_inf",           16'h0000, 3'b100);
        step(1'b0, 16'h0400, 16'h0400, "unf_min_sq",        16'h0000, 3'b001);
        step(1'b0, 16'h0000, 16'hBC00, "zero_x_neg1",       16'h8000, 3'b000);
        step(1'b0, 16'h3C00, 16'h3C00, "one_x_one",         16'h3C00, 3'b000);
        step(1'b0, 16'h3C01, 16'h3C01, "trunc_small",       16'h3C02, 3'b000);
        step(1'b0, 16'h3E00, 16'h3C01, "rne_tie_odd_up",    16'h3E02, 3'b000);
        step(1'b0, 16'h3E00, 16'h3C03, "rne_tie_even_keep", 16'h3E04, 3'b000);
        step(1'b0, 16'h3DA8, 16'h3DA8, "round_carry_exp",   16'h4000, 3'b000);
        step(1'b0, 16'h7800, 16'h4000, "ovf_e31",           16'h7C00, 3'b010);
        step(1'b0, 16'h7800, 16'h3C00, "e30_no_ovf",        16'h7800, 3'b000);
        step(1'b0, 16'hF800, 16'h4000, "ovf_neg_inf",       16'hFC00, 3'b010);
        step(1'b0, 16'h2000, 16'h1C00, "unf_e0",            16'h0000, 3'b001);
        step(1'b0, 16'h8400, 16'h0400, "unf_neg_zero",      16'h8000, 3'b001);
        step(1'b0, 16'h2000, 16'h2000, "e1_no_unf",         16'h0400, 3'b000);
        step(1'b0, 16'h7E00, 16'h0000, "nan_x_zero_exc",    16'h0000, 3'b100);
        step(1'b0, 16'hC000, 16'hC000, "neg_x_neg",         16'h4400, 3'b000);

        step(1'b1, 16'h4AAC, 16'hC713, "mid_rst",           16'h0000, 3'b000);
        step(1'b0, 16'hCC80, 16'h48C0, "after_rst",         16'hD958, 3'b000);
        step(1'b0, 16'h3C00, 16'h3C00, "flush",             16'h3C00, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
